counter_nb: RTL and testbench

- Parametrised N-bit multi-mode counter; next generation of the 4-bit mode counter.
- Adds width and step parameters, a registered carry/borrow flag (rco), a load strobe, and a saturating wrap-event counter.
- Sits as a leaf DUT in the counter test flow.
- Behavioural model and synthesised netlist are compared cycle-by-cycle by the tester/checker pair.

---
 rtl/counter_nb_pkg.sv | 37 +++
 rtl/counter_nb_next.sv | 43 ++++
 rtl/counter_nb.sv | 70 +++++++
 tb/tb_counter_nb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/counter_nb_pkg.sv
// Shared definitions for the counter_nb multi-mode counter: mode encodings
// and the unsigned {carry, next} arithmetic used by the next-state logic.
package counter_nb_pkg;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DN   = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Widest counter supported; the arithmetic is carried out at this size
   // and the carry is picked from bit 'width' of the extended result.
   localparam int MAX_W = 32;

   // Returns {carry, next}: bit 32 is the carry/borrow out of a
   // (width+1)-bit unsigned operation, bits [31:0] are the next count
   // masked to 'width' bits. A load never produces a carry.
   function automatic logic [MAX_W:0] calc_next(
      input logic [1:0]       mode,
      input logic [MAX_W-1:0] q,
      input logic [MAX_W-1:0] step,
      input logic [MAX_W-1:0] d,
      input logic [5:0]       width
   );
      logic [MAX_W:0] raw;
      logic [MAX_W:0] mask;
      raw  = '0;
      mask = (33'd1 << width) - 33'd1;
      case (mode)
         MODE_UP:   raw = {1'b0, q} + 33'd1;
         MODE_DN:   raw = {1'b0, q} - 33'd1;
         MODE_STEP: raw = {1'b0, q} + {1'b0, step};
         default:   raw = {1'b0, d};
      endcase
      return {raw[width], raw[MAX_W-1:0] & mask[MAX_W-1:0]};
   endfunction

endpackage

// File: rtl/counter_nb_next.sv
// Combinational next-count and carry/borrow logic for counter_nb.
// With COUNTER_NB_SAT_EN defined the count clamps at its limits instead of
// wrapping, and the carry flags each clamp event.
module counter_nb_next
   import counter_nb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 3
) (
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] next_q,
   output logic             carry
);

   localparam logic [5:0] W6 = 6'(WIDTH);

   logic [MAX_W:0] calc;
   logic           unused_calc;

   assign calc        = calc_next(mode, MAX_W'(q), MAX_W'(STEP), MAX_W'(d), W6);
   assign unused_calc = ^calc;

`ifdef COUNTER_NB_SAT_EN
   // Clamp: an overflow lands on all-ones, an underflow lands on zero.
   always_comb begin
      next_q = calc[WIDTH-1:0];
      carry  = calc[MAX_W];
      if (calc[MAX_W]) begin
         if (mode == MODE_DN) next_q = '0;
         else                 next_q = '1;
      end
   end
`else
   // Modulo wrap: the low WIDTH bits are the new count.
   always_comb begin
      next_q = calc[WIDTH-1:0];
      carry  = calc[MAX_W];
   end
`endif

endmodule

// File: rtl/counter_nb.sv
// counter_nb: parametrised multi-mode counter (up 1, down 1, up STEP, load)
// with registered carry/borrow flag, load strobe and a saturating wrap-event
// counter. Optional build macro: COUNTER_NB_SAT_EN (clamp instead of wrap).
module counter_nb
   import counter_nb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 3,
   parameter int WRAPW = 4
) (
   input  logic             cnt_clk,
   input  logic             cnt_reset,
   input  logic             cnt_enable,
   input  logic [1:0]       cnt_mode,
   input  logic [WIDTH-1:0] cnt_D,
   output logic [WIDTH-1:0] cnt_Q,
   output logic             cnt_rco,
   output logic             cnt_load,
   output logic [WRAPW-1:0] cnt_wraps
);

   logic [WIDTH-1:0] q_p1;
   logic             rco_p1;
   logic             load_p1;
   logic [WRAPW-1:0] wraps_p1;
   logic [WIDTH-1:0] next_q;
   logic             carry;

   // Saturating +1 for the wrap-event counter.
   function automatic logic [WRAPW-1:0] sat_inc(input logic [WRAPW-1:0] v);
      if (&v) return v;
      return v + WRAPW'(1);
   endfunction

   counter_nb_next #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_next (
      .mode   (cnt_mode),
      .q      (q_p1),
      .d      (cnt_D),
      .next_q (next_q),
      .carry  (carry)
   );

   // Output register stage: count, flags and wrap counter update together.
   always_ff @(posedge cnt_clk or negedge cnt_reset) begin
      if (!cnt_reset) begin
         q_p1     <= '0;
         rco_p1   <= 1'b0;
         load_p1  <= 1'b0;
         wraps_p1 <= '0;
      end else if (cnt_enable) begin
         q_p1    <= next_q;
         rco_p1  <= carry;
         load_p1 <= (cnt_mode == MODE_LOAD);
         if (cnt_mode == MODE_LOAD) wraps_p1 <= '0;
         else if (carry)            wraps_p1 <= sat_inc(wraps_p1);
      end else begin
         rco_p1  <= 1'b0;
         load_p1 <= 1'b0;
      end
   end

   assign cnt_Q     = q_p1;
   assign cnt_rco   = rco_p1;
   assign cnt_load  = load_p1;
   assign cnt_wraps = wraps_p1;

endmodule

// File: tb/tb_counter_nb.sv
// Self-checking bench for counter_nb (WIDTH=8, STEP=3, WRAPW=4). A reference
// model pushes the expected outputs for each driven edge into a queue; they
// are popped and compared one time unit after that edge.
module tb_counter_nb;

   localparam int WIDTH = 8;
   localparam int STEP  = 3;
   localparam int WRAPW = 4;
   localparam int MAXV  = (1 << WIDTH) - 1;
   localparam int MAXW  = (1 << WRAPW) - 1;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             rco;
      logic             load;
      logic [WRAPW-1:0] wraps;
   } exp_t;

   logic             cnt_clk = 1'b0;
   logic             cnt_reset = 1'b0;
   logic             cnt_enable = 1'b0;
   logic [1:0]       cnt_mode = 2'b00;
   logic [WIDTH-1:0] cnt_D = '0;
   logic [WIDTH-1:0] cnt_Q;
   logic             cnt_rco;
   logic             cnt_load;
   logic [WRAPW-1:0] cnt_wraps;

   exp_t exp_q[$];
   int   m_q, m_rco, m_load, m_wraps;
   int   n_checks = 0;
   int   n_errors = 0;

   counter_nb #(.WIDTH(WIDTH), .STEP(STEP), .WRAPW(WRAPW)) dut (
      .cnt_clk    (cnt_clk),
      .cnt_reset  (cnt_reset),
      .cnt_enable (cnt_enable),
      .cnt_mode   (cnt_mode),
      .cnt_D      (cnt_D),
      .cnt_Q      (cnt_Q),
      .cnt_rco    (cnt_rco),
      .cnt_load   (cnt_load),
      .cnt_wraps  (cnt_wraps)
   );

   always #5 cnt_clk = ~cnt_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q = 0; m_rco = 0; m_load = 0; m_wraps = 0;
   endtask

   // Drive one edge worth of stimulus, predict, then compare after the edge.
   task automatic drive(input logic en, input logic [1:0] mode, input logic [WIDTH-1:0] d);
      exp_t e;
      int   nq;
      bit   c;
      cnt_enable = en;
      cnt_mode   = mode;
      cnt_D      = d;
      c  = 1'b0;
      nq = m_q;
      if (!en) begin
         m_rco = 0; m_load = 0;
      end else if (mode == 2'b11) begin
         m_q = int'(d); m_load = 1; m_rco = 0; m_wraps = 0;
      end else begin
         if (mode == 2'b00)      begin nq = m_q + 1;    c = (nq > MAXV); end
         else if (mode == 2'b10) begin nq = m_q + STEP; c = (nq > MAXV); end
         else                    begin nq = m_q - 1;    c = (m_q == 0);  end
`ifdef COUNTER_NB_SAT_EN
         if (c) nq = (mode == 2'b01) ? 0 : MAXV;
`else
         if (nq < 0) nq = nq + MAXV + 1;
         if (nq > MAXV) nq = nq - (MAXV + 1);
`endif
         m_q    = nq;
         m_rco  = c ? 1 : 0;
         m_load = 0;
         if (c && m_wraps < MAXW) m_wraps++;
      end
      e.q = WIDTH'(m_q); e.rco = m_rco[0]; e.load = m_load[0]; e.wraps = WRAPW'(m_wraps);
      exp_q.push_back(e);
      @(posedge cnt_clk);
      #1;
      e = exp_q.pop_front();
      check("q", 32'(cnt_Q), 32'(e.q));
      check("rco", 32'(cnt_rco), 32'(e.rco));
      check("load", 32'(cnt_load), 32'(e.load));
      check("wraps", 32'(cnt_wraps), 32'(e.wraps));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_q"}, 32'(cnt_Q), 32'd0);
      check({tag, "_rco"}, 32'(cnt_rco), 32'd0);
      check({tag, "_load"}, 32'(cnt_load), 32'd0);
      check({tag, "_wraps"}, 32'(cnt_wraps), 32'd0);
   endtask

   initial begin
      model_reset();
      #1 check_zero("por");
      @(posedge cnt_clk); #1;
      check_zero("rst_hold");
      #2 cnt_reset = 1'b1;

      // Count, then assert reset asynchronously between edges.
      for (int i = 0; i < 5; i++) drive(1'b1, 2'b00, '0);
      check("run_q", 32'(cnt_Q), 32'd5);
      #2 cnt_reset = 1'b0;
      #1 check_zero("async_rst");
      @(posedge cnt_clk); #1;
      check_zero("rst_low_edge");
      #2 cnt_reset = 1'b1;
      model_reset();
      drive(1'b1, 2'b00, '0);
      check("first_after_rst", 32'(cnt_Q), 32'h01);

      // Load and hold.
      drive(1'b1, 2'b11, 8'hA5);
      check("load_q", 32'(cnt_Q), 32'hA5);
      check("load_strobe", 32'(cnt_load), 32'd1);
      drive(1'b0, 2'b00, 8'h00);
      check("hold_load_clr", 32'(cnt_load), 32'd0);

      // Up wrap and wrap-counter saturation.
      drive(1'b1, 2'b11, 8'hFE);
      drive(1'b1, 2'b00, '0);
      drive(1'b1, 2'b00, '0);
      check("upwrap_rco", 32'(cnt_rco), 32'd1);
      check("upwrap_wraps", 32'(cnt_wraps), 32'd1);
      for (int i = 0; i < 16 * (MAXV + 1); i++) drive(1'b1, 2'b00, '0);
      check("wraps_sat", 32'(cnt_wraps), 32'hF);

      // Step carry.
      drive(1'b1, 2'b11, 8'hFD);
      drive(1'b1, 2'b10, '0);
`ifdef COUNTER_NB_SAT_EN
      check("step_clamp", 32'(cnt_Q), 32'hFF);
`else
      check("step_land0", 32'(cnt_Q), 32'h00);
`endif
      check("step_rco", 32'(cnt_rco), 32'd1);
      drive(1'b1, 2'b10, '0);
      drive(1'b1, 2'b11, 8'hFF);
      drive(1'b1, 2'b10, '0);
      drive(1'b1, 2'b11, 8'hFE);
      drive(1'b1, 2'b10, '0);
      drive(1'b1, 2'b10, '0);

      // Down borrow, then hold with enable low.
      drive(1'b1, 2'b11, 8'h01);
      drive(1'b1, 2'b01, '0);
      drive(1'b1, 2'b01, '0);
      check("borrow_rco", 32'(cnt_rco), 32'd1);
      for (int i = 0; i < 3; i++) drive(1'b0, 2'b10, 8'h5A);

      // Back-to-back carries across modes.
      drive(1'b1, 2'b11, 8'h00);
      drive(1'b1, 2'b01, '0);
      drive(1'b1, 2'b00, '0);
      drive(1'b1, 2'b00, '0);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), WIDTH'($urandom));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
